// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I type definitions and load/store decode helpers
package rv32i_types;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    // funct3[1:0] size codes; 2'b11 is undefined and falls through to word
    localparam logic [1:0] SZ_B = SB[1:0];
    localparam logic [1:0] SZ_H = SH[1:0];

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == SZ_B) ? 1'b0 : (f3[1:0] == SZ_H) ? off[0] : (off != 2'b00);
    endfunction

    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == SZ_B) ? (4'b0001 << off) :
               (f3[1:0] == SZ_H) ? (4'b0011 << off) : 4'b1111;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/halfword of a read word and sign/zero-extends it
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    // halfwords are always even-aligned here, so only offset[1] picks the half
    always_comb begin
        b    = rdata[{offset, 3'b000} +: 8];
        h    = rdata[{offset[1], 4'b0000} +: 16];
        sx   = ~funct3[2];
        data = (funct3[1:0] == SZ_B) ? {{24{sx & b[7]}}, b} :
               (funct3[1:0] == SZ_H) ? {{16{sx & h[15]}}, h} : rdata;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer driving the data-cache handshake
module mem_access_ctrl
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              done,
    output logic              misaligned,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_byte_enable,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata
);

    if (DATA_W != 32) begin : g_width_check
        $error("mem_access_ctrl supports DATA_W=32 only");
    end

    mem_state_t        state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              mis_q;
    logic              req;
    logic              mis;
    logic [DATA_W-1:0] aligned;

    assign req = req_valid & (mem_read | mem_write);
    assign mis = is_misaligned(funct3, addr[1:0]);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // next state: DONE always returns to IDLE so an advancing instruction is never re-issued
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = mis ? DONE : ACCESS;
            ACCESS:  if (dmem_resp) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // capture the access on acceptance so the cache sees a stable request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
        end else if (state == IDLE && req && !mis) begin
            addr_q   <= addr;
            funct3_q <= funct3;
            wdata_q  <= wdata;
            write_q  <= mem_write;
        end
    end

    // misalignment flag for the DONE cycle and the registered load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q     <= 1'b0;
            load_data <= '0;
        end else begin
            mis_q <= (state == IDLE) && req && mis;
            if (state == ACCESS && dmem_resp && !write_q) load_data <= aligned;
        end
    end

    // outputs decoded from state; stall is gated by reset so it drops immediately
    always_comb begin
        stall      = rst_n & (((state == IDLE) & req) | (state == ACCESS));
        done       = state == DONE;
        misaligned = (state == DONE) & mis_q;
        dmem_read  = (state == ACCESS) & ~write_q;
        dmem_write = (state == ACCESS) & write_q;
    end

    assign dmem_address     = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem_wdata       = wdata_q << {addr_q[1:0], 3'b000};
    assign dmem_byte_enable = byte_mask(funct3_q, addr_q[1:0]);

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (aligned)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for the MEM-stage access controller
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        misaligned;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic        dmem_resp = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int vec = 0;
    int err = 0;
    logic [31:0] last_ld = '0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wr;
        logic        mis;
        logic [31:0] ld;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .funct3           (funct3),
        .addr             (addr),
        .wdata            (wdata),
        .stall            (stall),
        .load_data        (load_data),
        .done             (done),
        .misaligned       (misaligned),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata)
    );

    function automatic logic model_mis(input logic [2:0] f3, input logic [1:0] o);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return o[0];
            default: return o != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] o);
        logic [3:0] tb_b [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        case (f3[1:0])
            2'b00:   return tb_b[o];
            2'b01:   return o[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] r);
        logic [7:0]  by [4];
        logic [15:0] hw;
        for (int i = 0; i < 4; i++) by[i] = r[8*i +: 8];
        hw = {by[{o[1], 1'b1}], by[{o[1], 1'b0}]};
        case (f3)
            3'b000:  return by[o][7] ? {24'hFFFFFF, by[o]} : {24'h0, by[o]};
            3'b100:  return {24'h0, by[o]};
            3'b001:  return hw[15] ? {16'hFFFF, hw} : {16'h0, hw};
            3'b101:  return {16'h0, hw};
            default: return r;
        endcase
    endfunction

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int lat);
        exp_t e;
        int   st;
        e.wr    = wr;
        e.mis   = model_mis(f3, a[1:0]);
        e.addr  = {a[31:2], 2'b00};
        e.be    = model_be(f3, a[1:0]);
        e.wdata = wd << (8 * a[1:0]);
        e.ld    = (wr || e.mis) ? last_ld : model_ld(f3, a[1:0], rdat);
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        #1;
        vec++;
        if (stall !== 1'b1 || done !== 1'b0) begin
            err++; $display("FAIL req_cycle: stall=%b done=%b, want stall=1 done=0", stall, done);
        end
        st = 1;
        @(negedge clk);
        if (!e.mis) begin
            for (int i = 1; i <= lat; i++) begin
                vec++;
                if ({dmem_read, dmem_write} !== {~wr, wr}) begin
                    err++; $display("FAIL strobe[%0d]: rd/wr=%b%b want %b%b", i, dmem_read, dmem_write, ~wr, wr);
                end
                vec++;
                if (dmem_address !== sb_q[0].addr || dmem_byte_enable !== sb_q[0].be || dmem_wdata !== sb_q[0].wdata) begin
                    err++;
                    $display("FAIL bus[%0d]: addr=%h be=%b wdata=%h want addr=%h be=%b wdata=%h",
                             i, dmem_address, dmem_byte_enable, dmem_wdata, sb_q[0].addr, sb_q[0].be, sb_q[0].wdata);
                end
                if (stall) st++;
                if (i == lat) begin dmem_resp = 1'b1; dmem_rdata = rdat; end
                @(negedge clk);
                dmem_resp = 1'b0; dmem_rdata = $urandom;
            end
        end
        e = sb_q.pop_front();
        vec++;
        if (done !== 1'b1 || misaligned !== e.mis || stall !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
            err++;
            $display("FAIL done_cycle: done=%b mis=%b stall=%b rd=%b wr=%b want done=1 mis=%b stall=0 rd=0 wr=0",
                     done, misaligned, stall, dmem_read, dmem_write, e.mis);
        end
        vec++;
        if (load_data !== e.ld) begin
            err++; $display("FAIL load_data: got %h want %h", load_data, e.ld);
        end
        vec++;
        if (st !== (e.mis ? 1 : lat + 1)) begin
            err++; $display("FAIL stall_len: got %0d want %0d", st, e.mis ? 1 : lat + 1);
        end
        last_ld = e.ld;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vec++;
        if ({stall, done, misaligned, dmem_read, dmem_write} !== 5'b0 || load_data !== 32'h0) begin
            err++;
            $display("FAIL reset: st/dn/mis/rd/wr=%b%b%b%b%b ld=%h want 00000 ld=0",
                     stall, done, misaligned, dmem_read, dmem_write, load_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw;
        access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    endtask

    task automatic test_load_ext;
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 2);
        access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 1);
        access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 1);
        access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h1234_7F00, 1);
        access(1'b1, 1'b0, 3'b011, 32'h104, 32'h0, 32'hCAFE_F00D, 2);
    endtask

    task automatic test_store;
        access(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 32'h0, 2);
        access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_1234, 32'h0, 1);
        access(1'b1, 1'b1, 3'b010, 32'h208, 32'h5566_7788, 32'hFFFF_FFFF, 1);
    endtask

    task automatic test_misaligned;
        access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h1111_1111, 1);
        access(1'b0, 1'b1, 3'b001, 32'h105, 32'hBEEF, 32'h0, 1);
        access(1'b1, 1'b0, 3'b101, 32'h107, 32'h0, 32'h2222_2222, 1);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200;
        @(negedge clk);
        vec++;
        if (dmem_read !== 1'b1) begin
            err++; $display("FAIL mid_strobe: rd=%b want 1", dmem_read);
        end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if (dmem_read !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0) begin
            err++; $display("FAIL async_reset: rd=%b stall=%b ld=%h want 0 0 0", dmem_read, stall, load_data);
        end
        last_ld = '0;
        req_valid = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        dmem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vec++;
            if (done !== 1'b0 || load_data !== 32'h0) begin
                err++; $display("FAIL stray_resp[%0d]: done=%b ld=%h want 0 0", i, done, load_data);
            end
            @(negedge clk);
        end
        access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0BAD_F00D, 2);
    endtask

    task automatic test_back_to_back;
        access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hA5A5_5A5A, 1);
        access(1'b0, 1'b1, 3'b010, 32'h304, 32'h1357_9BDF, 32'h0, 1);
        access(1'b1, 1'b0, 3'b010, 32'h308, 32'h0, 32'h0F0F_F0F0, 1);
        access(1'b0, 1'b1, 3'b000, 32'h30E, 32'h0000_00C3, 32'h0, 1);
    endtask

    initial begin
        test_reset;
        test_lw;
        test_load_ext;
        test_store;
        test_misaligned;
        test_reset_mid;
        test_back_to_back;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
